// File: rtl/program_loader_if.sv
// Signal bundle between a byte-stream program source and the program loader,
// including the instruction-memory write port and processor hold/status.
interface program_loader_if;
    logic        start_load;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        load_end;
    logic        byte_ready;
    logic [7:0]  im_addr;
    logic [15:0] im_data;
    logic        im_we;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [8:0]  word_count;
    logic [7:0]  checksum;

    modport slave (
        input  start_load, byte_in, byte_valid, load_end,
        output byte_ready, im_addr, im_data, im_we, cpu_hold, done, err,
               word_count, checksum
    );

    modport master (
        output start_load, byte_in, byte_valid, load_end,
        input  byte_ready, im_addr, im_data, im_we, cpu_hold, done, err,
               word_count, checksum
    );
endinterface

// File: rtl/program_loader.sv
// Loads big-endian 16-bit instructions from a byte stream into instruction
// memory while holding the processor, then releases it to run from address 0.
module program_loader #(
    parameter logic [7:0] LAST_ADDR = 8'hFF
) (
    input logic             clk,
    input logic             rst_n,
    program_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD_HI, LOAD_LO, WRITE, RUN} state_t;

    state_t      state_q, state_d;
    logic [7:0]  im_addr_q, im_addr_d;
    logic [15:0] im_data_q, im_data_d;
    logic [8:0]  word_count_q, word_count_d;
    logic [7:0]  checksum_q, checksum_d;
    logic        err_q, err_d;
    logic        loading;
    logic        accept;

    assign loading = (state_q == LOAD_HI) || (state_q == LOAD_LO);
    // load_end takes priority over a byte offered in the same cycle, so refuse it
    assign bus.byte_ready = loading && !bus.load_end;
    assign accept         = bus.byte_ready && bus.byte_valid;

    always_comb begin
        // NOTE: every _d takes its hold value first so no path infers a latch.
        state_d      = state_q;
        im_addr_d    = im_addr_q;
        im_data_d    = im_data_q;
        word_count_d = word_count_q;
        checksum_d   = checksum_q;
        err_d        = err_q;

        case (state_q)
            IDLE, RUN: begin
                if (bus.start_load) begin
                    state_d      = LOAD_HI;
                    im_addr_d    = 8'h00;
                    word_count_d = 9'd0;
                    checksum_d   = 8'h00;
                    err_d        = 1'b0;
                end
            end
            LOAD_HI: begin
                if (bus.load_end) begin
                    state_d = RUN;
                end else if (accept) begin
                    im_data_d[15:8] = bus.byte_in;
                    checksum_d      = checksum_q ^ bus.byte_in;
                    state_d         = LOAD_LO;
                end
            end
            LOAD_LO: begin
                if (bus.load_end) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (accept) begin
                    im_data_d[7:0] = bus.byte_in;
                    checksum_d     = checksum_q ^ bus.byte_in;
                    state_d        = WRITE;
                end
            end
            WRITE: begin
                word_count_d = word_count_q + 9'd1;
                if (im_addr_q == LAST_ADDR) begin
                    state_d = RUN;
                end else begin
                    im_addr_d = im_addr_q + 8'd1;
                    state_d   = LOAD_HI;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            im_addr_q    <= 8'h00;
            im_data_q    <= 16'h0000;
            word_count_q <= 9'd0;
            checksum_q   <= 8'h00;
            err_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q      <= state_d;
            im_addr_q    <= im_addr_d;
            im_data_q    <= im_data_d;
            word_count_q <= word_count_d;
            checksum_q   <= checksum_d;
            err_q        <= err_d;
        end
    end

    assign bus.im_addr    = im_addr_q;
    assign bus.im_data    = im_data_q;
    assign bus.im_we      = (state_q == WRITE);
    assign bus.cpu_hold   = (state_q != RUN);
    assign bus.done       = (state_q == RUN);
    assign bus.err        = err_q;
    assign bus.word_count = word_count_q;
    assign bus.checksum   = checksum_q;
endmodule
